// File: rtl/arm_mul_pkg.sv
// arm_mul_pkg: shared types and constants for the iterative multiply unit.
// Optional build macro ARM_MUL_EARLY_TERM_EN is consumed by the RTL files.
package arm_mul_pkg;

   typedef enum logic [1:0] {
      MUL_OP   = 2'b00,
      MLA_OP   = 2'b01,
      UMULL_OP = 2'b10,
      SMULL_OP = 2'b11
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } mul_state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic is_long(input mul_op_t op);
      return (op == UMULL_OP) || (op == SMULL_OP);
   endfunction

endpackage

// File: rtl/arm_mul_unit_core.sv
// arm_mul_unit_core: radix-2 shift-add datapath (partial product, multiplier, counter).
// With ARM_MUL_EARLY_TERM_EN defined it also reports when the remaining multiplier bits are zero.
module arm_mul_core
   import arm_mul_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   ma_in,
   input  logic [WIDTH-1:0]   mb_in,
   output logic [2*WIDTH-1:0] prod,
`ifdef ARM_MUL_EARLY_TERM_EN
   output logic               zero_rem,
`endif
   output logic [CNT_W-1:0]   cnt
);

   logic [WIDTH-1:0] ma;
   logic [WIDTH-1:0] mb;
   logic [WIDTH-1:0] ph;
   logic [WIDTH-1:0] pl;
   logic [WIDTH:0]   sum;

   // Conditional add of the multiplicand into the high half, carry kept in bit WIDTH.
   always_comb begin
      sum = {1'b0, ph};
      if (mb[0])
         sum = {1'b0, ph} + {1'b0, ma};
   end

   assign prod = {ph, pl};

`ifdef ARM_MUL_EARLY_TERM_EN
   assign zero_rem = (mb[WIDTH-1:1] == '0);
`endif

   // Load operands on acceptance; otherwise shift {carry,P,mb} right once per step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ma  <= '0;
         mb  <= '0;
         ph  <= '0;
         pl  <= '0;
         cnt <= '0;
      end else if (load) begin
         ma  <= ma_in;
         mb  <= mb_in;
         ph  <= '0;
         pl  <= '0;
         cnt <= CNT_W'(WIDTH);
      end else if (step) begin
         ph  <= sum[WIDTH:1];
         pl  <= {sum[0], pl[WIDTH-1:1]};
         mb  <= {1'b0, mb[WIDTH-1:1]};
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/arm_mul_unit.sv
// arm_mul_unit: multi-cycle MUL/MLA/UMULL/SMULL with start/busy/done handshake.
// Define ARM_MUL_EARLY_TERM_EN to stop iterating once the multiplier is exhausted.
module arm_mul_unit
   import arm_mul_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags
);

   mul_state_t       state;
   mul_op_t          op_r;
   logic [WIDTH-1:0] acc_r;
   logic             neg_r;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               neg_in;
   logic               load;
   logic               step;
   logic               last_step;
   logic [2*WIDTH-1:0] prod;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] prod_al;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   lo_n;
   logic [WIDTH-1:0]   hi_n;
   logic               n_n;
   logic               z_n;
`ifdef ARM_MUL_EARLY_TERM_EN
   logic               zero_rem;
`endif

   // Operand magnitudes; only SMULL treats the inputs as signed.
   always_comb begin
      a_mag  = a;
      b_mag  = b;
      neg_in = 1'b0;
      if (mul_op_t'(op) == SMULL_OP) begin
         if (a[WIDTH-1]) a_mag = -a;
         if (b[WIDTH-1]) b_mag = -b;
         neg_in = a[WIDTH-1] ^ b[WIDTH-1];
      end
   end

   assign load = (state == IDLE) && start;
   assign step = (state == RUN);

`ifdef ARM_MUL_EARLY_TERM_EN
   assign last_step = (cnt == CNT_W'(1)) || zero_rem;
`else
   assign last_step = (cnt == CNT_W'(1));
`endif

   arm_mul_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .step     (step),
      .ma_in    (a_mag),
      .mb_in    (b_mag),
      .prod     (prod),
`ifdef ARM_MUL_EARLY_TERM_EN
      .zero_rem (zero_rem),
`endif
      .cnt      (cnt)
   );

   // Align, apply sign and accumulate, then derive N/Z from the reported bits.
   always_comb begin
`ifdef ARM_MUL_EARLY_TERM_EN
      prod_al = prod >> cnt;
`else
      prod_al = prod;
`endif
      prod_s = neg_r ? -prod_al : prod_al;
      lo_n   = prod_s[WIDTH-1:0];
      if (op_r == MLA_OP)
         lo_n = prod_s[WIDTH-1:0] + acc_r;
      hi_n = '0;
      n_n  = lo_n[WIDTH-1];
      z_n  = (lo_n == '0);
      if (is_long(op_r)) begin
         hi_n = prod_s[2*WIDTH-1:WIDTH];
         n_n  = hi_n[WIDTH-1];
         z_n  = (prod_s == '0);
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         op_r      <= MUL_OP;
         acc_r     <= '0;
         neg_r     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result_lo <= '0;
         result_hi <= '0;
         flags     <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_r  <= mul_op_t'(op);
                  acc_r <= acc;
                  neg_r <= neg_in;
                  busy  <= 1'b1;
`ifdef ARM_MUL_EARLY_TERM_EN
                  state <= (b == '0) ? FIX : RUN;
`else
                  state <= RUN;
`endif
               end
            end
            RUN: begin
               if (last_step)
                  state <= FIX;
            end
            FIX: begin
               result_lo     <= lo_n;
               result_hi     <= hi_n;
               flags[FLAG_N] <= n_n;
               flags[FLAG_Z] <= z_n;
               flags[FLAG_C] <= 1'b0;
               flags[FLAG_V] <= 1'b0;
               busy          <= 1'b0;
               state         <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
